// File: rtl/inv_aes_pkg.sv
// Shared definitions for the inverse-AES block loader.
//   NBYTES  : bytes per cipher block
//   BLK_W   : block / key width in bits
//   CNT_W   : width of the saturating byte counters (0..16)
//   state_t : loader FSM states
package inv_aes_pkg;
  localparam int NBYTES = 16;
  localparam int BLK_W  = 128;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
endpackage

// File: rtl/byte_shreg128.sv
// MSB-first 16-byte assembly register with a saturating byte count.
//   clk, rst_n : clock, async active-low reset
//   i_shift    : write i_byte into the next free slot (ignored when full)
//   i_clr      : clear the count; together with i_shift it restarts the
//                register with i_byte as byte 0
//   i_byte     : incoming byte
//   o_data     : assembled block, byte 0 in [127:120]
//   o_full     : all 16 bytes present
module byte_shreg128
  import inv_aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic [7:0]       i_byte,
  output logic [BLK_W-1:0] o_data,
  output logic             o_full
);

  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_data;
  logic [6:0]       w_lsb;

  // Slot for byte n starts at bit (15-n)*8; ~cnt[3:0] is 15-n.
  assign w_lsb  = {~r_cnt[3:0], 3'b000};
  assign o_full = (r_cnt == CNT_W'(NBYTES));
  assign o_data = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_shift && i_clr) begin
      // Restart: old contents dropped, new byte becomes byte 0.
      r_data <= {i_byte, {(BLK_W-8){1'b0}}};
      r_cnt  <= CNT_W'(1);
    end else if (i_shift && !o_full) begin
      r_data[w_lsb +: 8] <= i_byte;
      r_cnt              <= r_cnt + CNT_W'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/inv_aes_loader.sv
// Byte-serial loader feeding a downstream inverse-AES core.
// Assembles a 128-bit key and 128-bit ciphertext blocks from a byte
// stream, presents them on key_in/data_in and holds en_inv_aes high until
// the core pulses aes_done. The data side is double-buffered: the next
// block fills a shadow register while the current one is being decrypted.
//   clk, reset   : clock, async active-low reset
//   byte_in      : key or ciphertext byte
//   byte_valid   : byte_in valid
//   byte_is_key  : byte_in is a key byte
//   byte_ready   : loader accepts byte_in this cycle
//   aes_done     : one-cycle strobe, current block finished
//   data_in      : ciphertext block to the core
//   key_in       : key to the core
//   en_inv_aes   : core enable (high in RUN)
//   busy         : high in RUN and GAP
//   err_key      : sticky, key byte offered while busy
module inv_aes_loader #(
  parameter int NBYTES  = 16,  // only 16 is supported
  parameter int GAP_CYC = 1    // 1..15 idle cycles between blocks
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_is_key,
  output logic                  byte_ready,
  input  logic                  aes_done,
  output logic [NBYTES*8-1:0]   data_in,
  output logic [NBYTES*8-1:0]   key_in,
  output logic                  en_inv_aes,
  output logic                  busy,
  output logic                  err_key
);
  import inv_aes_pkg::*;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_gap_cnt;
  logic             w_load, w_busy;
  logic             w_key_shift, w_key_clr, w_dat_shift;
  logic             w_key_ok, w_dat_ok;
  logic [BLK_W-1:0] w_key_reg, w_dat_reg;

  assign w_busy     = (r_state != ST_IDLE);
  assign byte_ready = byte_is_key ? !w_busy : !w_dat_ok;

  assign w_key_shift = byte_valid & byte_is_key & !w_busy;
  // A key byte arriving on a complete key starts a new key.
  assign w_key_clr   = w_key_shift & w_key_ok;
  assign w_dat_shift = byte_valid & !byte_is_key & !w_dat_ok;

  byte_shreg128 u_key (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_key_clr),
    .i_shift (w_key_shift),
    .i_byte  (byte_in),
    .o_data  (w_key_reg),
    .o_full  (w_key_ok)
  );

  // w_load needs dat_ok while a shift needs !dat_ok, so they never collide.
  byte_shreg128 u_dat (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_load),
    .i_shift (w_dat_shift),
    .i_byte  (byte_in),
    .o_data  (w_dat_reg),
    .o_full  (w_dat_ok)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: if (w_dat_ok && w_key_ok) begin
        w_next = ST_RUN;
        w_load = 1'b1;
      end
      ST_RUN:  if (aes_done) w_next = ST_GAP;
      ST_GAP:  if (r_gap_cnt == GAP_LAST) begin
        if (w_dat_ok) begin
          w_next = ST_RUN;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      data_in   <= '0;
      key_in    <= '0;
      err_key   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 4'd1 : 4'd0;
      if (w_load) begin
        data_in <= w_dat_reg;
        key_in  <= w_key_reg;
      end
      if (byte_valid && byte_is_key && w_busy) err_key <= 1'b1;
    end
  end

  assign en_inv_aes = (r_state == ST_RUN);
  assign busy       = w_busy;

endmodule

// File: tb/tb_inv_aes_loader.sv
// Directed bench for inv_aes_loader (GAP_CYC = 1).
module tb_inv_aes_loader;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_is_key = 1'b0;
  logic         byte_ready;
  logic         aes_done = 1'b0;
  logic [127:0] data_in, key_in;
  logic         en_inv_aes, busy, err_key;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] DAT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] DAT3 = 128'h5a0102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY5 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] DAT5 = 128'h101112131415161718191a1b1c1d1e1f;

  inv_aes_loader #(.NBYTES(16), .GAP_CYC(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_is_key (byte_is_key),
    .byte_ready  (byte_ready),
    .aes_done    (aes_done),
    .data_in     (data_in),
    .key_in      (key_in),
    .en_inv_aes  (en_inv_aes),
    .busy        (busy),
    .err_key     (err_key)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until accepted (bounded).
  task automatic send(input logic [7:0] b, input logic k);
    bit done = 1'b0;
    byte_valid  = 1'b1;
    byte_in     = b;
    byte_is_key = k;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (byte_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!done) chk("send_timeout", {127'b0, done}, 128'd1);
  endtask

  task automatic send_blk(input logic [127:0] blk, input logic k);
    logic [127:0] t;
    t = blk;
    for (int i = 0; i < 16; i++) begin
      send(t[127:120], k);
      t = t << 8;
    end
  endtask

  task automatic pulse_done();
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
  endtask

  initial begin
    logic [127:0] t;
    // ---- reset state
    #3;
    chk("rst_data_in", data_in, '0);
    chk("rst_key_in",  key_in, '0);
    chk("rst_en",      {127'b0, en_inv_aes}, '0);
    chk("rst_busy",    {127'b0, busy}, '0);
    chk("rst_ready",   {127'b0, byte_ready}, 128'd1);
    tick();
    reset = 1'b1;
    tick();

    // ---- scenario 1: key then data, latency
    send_blk(KEY1, 1'b1);
    send_blk(DAT1, 1'b0);
    chk("s1_en_not_yet", {127'b0, en_inv_aes}, '0);
    tick();
    chk("s1_en",      {127'b0, en_inv_aes}, 128'd1);
    chk("s1_busy",    {127'b0, busy}, 128'd1);
    chk("s1_key_in",  key_in, KEY1);
    chk("s1_data_in", data_in, DAT1);

    // ---- scenario 2: fill shadow with zeros during RUN
    send_blk('0, 1'b0);
    chk("s2_run_en",     {127'b0, en_inv_aes}, 128'd1);
    chk("s2_run_stable", data_in, DAT1);

    // ---- scenario 4: key byte while busy
    byte_valid = 1'b1; byte_is_key = 1'b1; byte_in = 8'haa;
    #1;
    chk("s4_ready", {127'b0, byte_ready}, '0);
    tick();
    chk("s4_err",    {127'b0, err_key}, 128'd1);
    chk("s4_key_in", key_in, KEY1);

    // ---- scenario 3: data byte offered with full shadow
    byte_is_key = 1'b0; byte_in = 8'h5a;
    #1;
    chk("s3_ready_full", {127'b0, byte_ready}, '0);
    pulse_done();
    chk("s2_gap_en",   {127'b0, en_inv_aes}, '0);
    chk("s2_gap_busy", {127'b0, busy}, 128'd1);
    chk("s4_err_sticky", {127'b0, err_key}, 128'd1);
    chk("s3_ready_gap", {127'b0, byte_ready}, '0);
    tick();
    chk("s2_run_en2",   {127'b0, en_inv_aes}, 128'd1);
    chk("s2_data_zero", data_in, '0);
    chk("s2_key_kept",  key_in, KEY1);
    chk("s3_ready_now", {127'b0, byte_ready}, 128'd1);
    tick();  // held 0x5a is taken on this edge
    byte_valid = 1'b0;
    t = DAT3 << 8;
    for (int i = 0; i < 15; i++) begin
      send(t[127:120], 1'b0);
      t = t << 8;
    end
    pulse_done();
    tick();
    chk("s3_held_byte", data_in, DAT3);
    // no data pending: back to IDLE after the gap
    pulse_done();
    tick();
    chk("s3_idle_busy", {127'b0, busy}, '0);

    // ---- scenario 6: 17th key byte restarts the key
    send(8'h11, 1'b1);
    chk("s6_key_ok",  {127'b0, dut.w_key_ok}, '0);
    chk("s6_key_cnt", {123'b0, dut.u_key.r_cnt}, 128'd1);
    chk("s6_key_b0",  {120'b0, dut.w_key_reg[127:120]}, 128'h11);
    chk("s6_no_run",  {127'b0, en_inv_aes}, '0);

    // ---- scenario 5: reset after 7 data bytes
    for (int i = 0; i < 7; i++) send(8'hc0 + 8'(i), 1'b0);
    reset = 1'b0;
    byte_valid = 1'b1; byte_is_key = 1'b0; byte_in = 8'hee;
    #1;
    chk("s5_data_in", data_in, '0);
    chk("s5_key_in",  key_in, '0);
    chk("s5_en",      {127'b0, en_inv_aes}, '0);
    chk("s5_busy",    {127'b0, busy}, '0);
    chk("s5_err",     {127'b0, err_key}, '0);
    chk("s5_ready",   {127'b0, byte_ready}, 128'd1);
    tick();
    reset = 1'b1;
    byte_valid = 1'b0;
    tick();
    send_blk(KEY5, 1'b1);
    send_blk(DAT5, 1'b0);
    chk("s5_en_not_yet", {127'b0, en_inv_aes}, '0);
    tick();
    chk("s5_en_run",  {127'b0, en_inv_aes}, 128'd1);
    chk("s5_fresh_d", data_in, DAT5);
    chk("s5_fresh_k", key_in, KEY5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inv_aes_loader.md
INV_AES_LOADER -- requirements
Module: inv_aes_loader

Interface
REQ-001 Parameter NBYTES, default 16, bytes per 128-bit block; only 16 is legal.
REQ-002 Parameter GAP_CYC, default 1, idle cycles with en_inv_aes low between consecutive blocks; range 1..15.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 byte_in  in  8  ciphertext or key byte.
REQ-006 byte_valid  in  1  byte_in is valid this cycle.
REQ-007 byte_is_key  in  1  qualifies byte_in as a key byte (1) or a data byte (0).
REQ-008 byte_ready  out  1  the loader accepts byte_in this cycle.
REQ-009 aes_done  in  1  one-cycle strobe from the downstream decryptor: the current block is finished.
REQ-010 data_in  out  128  ciphertext block presented downstream.
REQ-011 key_in  out  128  cipher key presented downstream.
REQ-012 en_inv_aes  out  1  enables the downstream decryptor.
REQ-013 busy  out  1  high in RUN and GAP.
REQ-014 err_key  out  1  sticky; a key byte was offered while busy.

Function
REQ-015 A transfer occurs when byte_valid and byte_ready are both high on a rising edge; no byte is accepted otherwise.
REQ-016 Byte assembly is MSB-first: the first accepted byte lands in [127:120] and the 16th in [7:0].
REQ-017 Key bytes fill the key shift register (key_cnt 0..16); key_ok is set when key_cnt reaches 16.
REQ-018 A key byte accepted while key_ok=1 clears key_cnt and key_ok, and the byte becomes byte 0 of a new key.
REQ-019 Data bytes fill the shadow data register (dat_cnt 0..16); dat_ok is set when dat_cnt reaches 16.
REQ-020 byte_ready = !dat_ok when byte_is_key=0.
REQ-021 byte_ready = !busy when byte_is_key=1.
REQ-022 byte_valid & byte_is_key while busy sets err_key; the byte is not accepted.
REQ-023 FSM states are IDLE, RUN and GAP.
REQ-024 IDLE -> RUN on the first cycle with dat_ok & key_ok; in that same edge: shadow to data_in, key register to key_in, dat_cnt and dat_ok cleared.
REQ-025 RUN holds en_inv_aes=1, and data_in/key_in are stable throughout RUN.
REQ-026 RUN -> GAP on aes_done; aes_done in IDLE or GAP is ignored.
REQ-027 GAP holds en_inv_aes=0 for exactly GAP_CYC cycles, then goes to RUN if dat_ok (performing the REQ-024 transfer) or to IDLE otherwise.
REQ-028 The shadow register may fill during RUN/GAP, giving double buffering: the next block loads with no byte-side stall.
REQ-029 If a data byte transfer completes dat_ok on the same edge as the REQ-024/027 check, the new block is not used until the following cycle.
REQ-030 Latency: en_inv_aes rises 1 cycle after the edge accepting the last needed byte (in IDLE).
REQ-031 Counters saturate at 16 and never wrap.
REQ-032 The sole exception to REQ-031 is the REQ-018 key restart.

Reset
REQ-033 reset=0 immediately forces the following values, regardless of clk: state IDLE; data_in, key_in and both shift registers 0; key_cnt, dat_cnt, key_ok, dat_ok 0; en_inv_aes, busy, err_key 0.
REQ-034 byte_ready follows REQ-020/021 from the reset state: it is 1 during reset, and a transfer attempted during reset is discarded.
REQ-035 Reset mid-block drops en_inv_aes and discards any partial key or data.
REQ-036 Release is synchronised: state leaves reset on the first rising edge after reset=1.

Structure
REQ-037 Shared package inv_aes_pkg holds the state enum, NBYTES, and the 128-bit block width constant.
REQ-038 Sub-module byte_shreg128 (MSB-first 16-byte shift register with saturating count, clear, and full flag) is instantiated twice, once for the key and once for the data shadow.
REQ-039 The target size is 150-250 RTL lines.

Verification
REQ-040 Directed scenario 1:
- Stimulus: 16 key bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c, then 16 data bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- Response: key_in=2b7e151628aed2a6abf7158809cf4f3c, data_in=3925841d02dc09fbdc118597196a0b32, en_inv_aes=1 one cycle after the last byte.
REQ-041 Directed scenario 2:
- Stimulus: 16 data bytes of 0x00 during RUN, then aes_done.
- Response: GAP lasts GAP_CYC=1 cycle, then RUN with data_in=0; key_in is unchanged.
REQ-042 Directed scenario 3:
- Stimulus: with the shadow full, offer a data byte.
- Response: byte_ready=0, the byte is held, and it is accepted 1 cycle after the shadow transfer.
REQ-043 Directed scenario 4:
- Stimulus: a key byte 0xaa while busy.
- Response: byte_ready=0, err_key=1 (sticky), key_in is unchanged.
REQ-044 Directed scenario 5:
- Stimulus: reset=0 for 1 cycle after 7 data bytes.
- Response: all outputs are 0 with byte_ready=1, and the next 16 bytes form a fresh block.
REQ-045 Directed scenario 6:
- Stimulus: a 17th key byte 0x11 after key_ok, with no data pending.
- Response: key_ok=0, key_cnt=1, and the register [127:120]=0x11.
